pe_result_drain: RTL and testbench

- Output-side collector for the systolic process_element array.
- On the array's done pulse, snapshots all PE_NUM accumulators in one cycle, then streams them out one per handshake on a valid/ready port.
- Each word is signed-saturated to OUT_WIDTH.
- Feeds the write-back path; the array is free to start the next tile right after the snapshot.

---
 rtl/pe_pkg.sv | 23 ++
 rtl/sat_trunc.sv | 41 ++++
 rtl/pe_result_drain.sv | 150 +++++++++++++++
 tb/tb_pe_result_drain.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
//------------------------------------------------------------------------------
// Module   : pe_pkg
// Purpose  : Shared constants and types for the process_element array blocks.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pe_pkg;

  localparam int MAC_WIDTH = 9;
  localparam int ACC_WIDTH = MAC_WIDTH * 4 + 1;
  localparam int PE_NUM    = 4;

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

endpackage

`default_nettype wire

// File: rtl/sat_trunc.sv
//------------------------------------------------------------------------------
// Module   : sat_trunc
// Purpose  : Combinational signed saturation from IN_WIDTH down to OUT_WIDTH,
//            with a flag marking words that were clamped.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sat_trunc #(
  parameter int IN_WIDTH  = 37,
  parameter int OUT_WIDTH = 16
) (
  input  logic [IN_WIDTH-1:0]  data_i,
  output logic [OUT_WIDTH-1:0] data_o,
  output logic                 sat_o
);

  generate
    if (OUT_WIDTH == IN_WIDTH) begin : g_bypass
      assign data_o = data_i;
      assign sat_o  = 1'b0;
    end else begin : g_sat
      localparam logic [OUT_WIDTH-1:0] c_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      localparam logic [OUT_WIDTH-1:0] c_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

      // The value fits only if every bit from the output sign bit upward
      // matches the input sign.
      logic [IN_WIDTH-OUT_WIDTH:0] w_hi;
      logic                        w_ovf;

      assign w_hi   = data_i[IN_WIDTH-1:OUT_WIDTH-1];
      assign w_ovf  = ~((&w_hi) | ~(|w_hi));
      assign data_o = w_ovf ? (data_i[IN_WIDTH-1] ? c_MIN : c_MAX)
                            : data_i[OUT_WIDTH-1:0];
      assign sat_o  = w_ovf;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/pe_result_drain.sv
//------------------------------------------------------------------------------
// Module   : pe_result_drain
// Purpose  : Snapshots all PE accumulators on done_i and streams them out,
//            saturated to OUT_WIDTH, one word per valid/ready handshake.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pe_result_drain #(
  parameter int PE_NUM    = pe_pkg::PE_NUM,
  parameter int MAC_WIDTH = pe_pkg::MAC_WIDTH,
  parameter int ACC_WIDTH = MAC_WIDTH * 4 + 1,
  parameter int OUT_WIDTH = 16,
  parameter int IDX_WIDTH = $clog2(PE_NUM)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [PE_NUM*ACC_WIDTH-1:0] acc_i,
  input  logic                        done_i,
  input  logic                        out_ready_i,
  input  logic                        clr_overrun_i,
  output logic                        out_valid_o,
  output logic [OUT_WIDTH-1:0]        out_data_o,
  output logic [IDX_WIDTH-1:0]        out_idx_o,
  output logic                        out_last_o,
  output logic                        out_sat_o,
  output logic                        busy_o,
  output logic                        overrun_o
);

  import pe_pkg::*;

  localparam logic [IDX_WIDTH-1:0] c_LAST_IDX = IDX_WIDTH'(PE_NUM - 1);

  drain_state_e         r_state, w_state_nxt;
  logic [IDX_WIDTH-1:0] r_idx, w_idx_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_ovr;
  logic [OUT_WIDTH-1:0] r_data;
  logic                 r_last, r_sat;
  logic                 w_load, w_upd, w_set_ovr, w_xfer, w_final;
  logic [ACC_WIDTH-1:0] r_snap [PE_NUM];
  logic [ACC_WIDTH-1:0] w_sel;
  logic [OUT_WIDTH-1:0] w_sat_data;
  logic                 w_sat_flag;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;
    w_load      = 1'b0;
    w_upd       = 1'b0;
    w_set_ovr   = 1'b0;
    w_xfer      = r_valid & out_ready_i;
    w_final     = w_xfer && (r_idx == c_LAST_IDX);

    case (r_state)
      IDLE: begin
        if (done_i) begin
          w_load      = 1'b1;
          w_upd       = 1'b1;
          w_idx_nxt   = '0;
          w_valid_nxt = 1'b1;
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_final) begin
          w_idx_nxt = '0;
          if (done_i) begin
            // Back-to-back tile: reload without a bubble.
            w_load = 1'b1;
            w_upd  = 1'b1;
          end else begin
            w_valid_nxt = 1'b0;
            w_state_nxt = IDLE;
          end
        end else if (w_xfer) begin
          w_idx_nxt = r_idx + 1'b1;
          w_upd     = 1'b1;
        end
        w_set_ovr = done_i & ~w_final;
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
        w_idx_nxt   = '0;
      end
    endcase

    // A fresh tile is not in the snapshot bank yet, so word 0 comes straight
    // from the input bus to keep the done-to-valid latency at one cycle.
    w_sel = w_load ? acc_i[ACC_WIDTH-1:0] : r_snap[w_idx_nxt];
  end

  sat_trunc #(
    .IN_WIDTH  (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_sat_trunc (
    .data_i (w_sel),
    .data_o (w_sat_data),
    .sat_o  (w_sat_flag)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < PE_NUM; k++) r_snap[k] <= '0;
    end else if (w_load) begin
      for (int k = 0; k < PE_NUM; k++) r_snap[k] <= acc_i[k*ACC_WIDTH +: ACC_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
      if (w_set_ovr)          r_ovr <= 1'b1;
      else if (clr_overrun_i) r_ovr <= 1'b0;
      if (!w_valid_nxt) begin
        r_data <= '0;
        r_last <= 1'b0;
        r_sat  <= 1'b0;
      end else if (w_upd) begin
        r_data <= w_sat_data;
        r_last <= (w_idx_nxt == c_LAST_IDX);
        r_sat  <= w_sat_flag;
      end
    end
  end

  assign out_valid_o = r_valid;
  assign out_data_o  = r_data;
  assign out_idx_o   = r_idx;
  assign out_last_o  = r_last;
  assign out_sat_o   = r_sat;
  assign busy_o      = (r_state == DRAIN);
  assign overrun_o   = r_ovr;

endmodule

`default_nettype wire

// File: tb/tb_pe_result_drain.sv
//------------------------------------------------------------------------------
// Module   : tb_pe_result_drain
// Purpose  : Scoreboard bench for pe_result_drain with directed tiles.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pe_result_drain;

  localparam int PE_N  = 4;
  localparam int ACC_W = 37;
  localparam int OUT_W = 16;
  localparam int IDX_W = 2;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic [PE_N*ACC_W-1:0]   acc_i;
  logic                    done_i;
  logic                    out_ready_i;
  logic                    clr_overrun_i;
  logic                    out_valid_o;
  logic [OUT_W-1:0]        out_data_o;
  logic [IDX_W-1:0]        out_idx_o;
  logic                    out_last_o;
  logic                    out_sat_o;
  logic                    busy_o;
  logic                    overrun_o;

  pe_result_drain #(
    .PE_NUM    (PE_N),
    .MAC_WIDTH (9),
    .ACC_WIDTH (ACC_W),
    .OUT_WIDTH (OUT_W),
    .IDX_WIDTH (IDX_W)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .acc_i         (acc_i),
    .done_i        (done_i),
    .out_ready_i   (out_ready_i),
    .clr_overrun_i (clr_overrun_i),
    .out_valid_o   (out_valid_o),
    .out_data_o    (out_data_o),
    .out_idx_o     (out_idx_o),
    .out_last_o    (out_last_o),
    .out_sat_o     (out_sat_o),
    .busy_o        (busy_o),
    .overrun_o     (overrun_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [IDX_W-1:0] idx;
    logic             last;
    logic             sat;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input int data, input int idx, input bit sat);
    exp_t e;
    e.data = OUT_W'(data);
    e.idx  = IDX_W'(idx);
    e.last = (idx == PE_N - 1);
    e.sat  = sat;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_acc(input longint a0, input longint a1, input longint a2, input longint a3);
    acc_i = {ACC_W'(a3), ACC_W'(a2), ACC_W'(a1), ACC_W'(a0)};
  endtask

  task automatic pulse_done();
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
  endtask

  task automatic wait_idle(input string name, output int n);
    n = 0;
    while ((out_valid_o || sb_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, 32'(n < 200), 32'd1);
  endtask

  // Monitor: every presented word must match the head of the scoreboard;
  // it is popped only when the handshake completes.
  always @(negedge clk) begin
    exp_t e;
    if (rstn && out_valid_o) begin
      if (sb_q.size() == 0) begin
        check("unexpected_word", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q[0];
        check("data", 32'(out_data_o), 32'(e.data));
        check("idx",  32'(out_idx_o),  32'(e.idx));
        check("last", 32'(out_last_o), 32'(e.last));
        check("sat",  32'(out_sat_o),  32'(e.sat));
        if (out_ready_i) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int pat[7] = '{1, 0, 0, 1, 0, 1, 1};

    rstn          = 1'b0;
    acc_i         = '0;
    done_i        = 1'b0;
    out_ready_i   = 1'b0;
    clr_overrun_i = 1'b0;
    #2;
    check("rst_valid",   32'(out_valid_o), 32'd0);
    check("rst_busy",    32'(busy_o),      32'd0);
    check("rst_overrun", 32'(overrun_o),   32'd0);
    check("rst_idx",     32'(out_idx_o),   32'd0);
    check("rst_data",    32'(out_data_o),  32'd0);
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // Basic drain at full throughput
    out_ready_i = 1'b1;
    set_acc(1, 2, 3, 4);
    push(1, 0, 0); push(2, 1, 0); push(3, 2, 0); push(4, 3, 0);
    check("pre_valid", 32'(out_valid_o), 32'd0);
    pulse_done();
    check("first_valid", 32'(out_valid_o), 32'd1);
    check("first_busy",  32'(busy_o),      32'd1);
    wait_idle("basic", n);
    check("basic_cycles",  32'(n),         32'd4);
    check("basic_busy",    32'(busy_o),    32'd0);
    check("basic_overrun", 32'(overrun_o), 32'd0);

    // Backpressure
    push(1, 0, 0); push(2, 1, 0); push(3, 2, 0); push(4, 3, 0);
    pulse_done();
    for (int i = 0; i < 7; i++) begin
      out_ready_i = pat[i][0];
      tick();
    end
    out_ready_i = 1'b1;
    check("bp_done_valid", 32'(out_valid_o), 32'd0);
    check("bp_queue",      32'(sb_q.size()), 32'd0);
    wait_idle("bp", n);

    // Saturation
    set_acc(40000, -40000, 32767, -32768);
    push(32767, 0, 1); push(-32768, 1, 1); push(32767, 2, 0); push(-32768, 3, 0);
    pulse_done();
    wait_idle("sat", n);

    // Overrun: done during drain is dropped
    set_acc(1, 2, 3, 4);
    push(1, 0, 0); push(2, 1, 0); push(3, 2, 0); push(4, 3, 0);
    pulse_done();
    tick();
    set_acc(9, 9, 9, 9);
    pulse_done();
    check("ovr_set", 32'(overrun_o), 32'd1);
    wait_idle("ovr", n);
    check("ovr_sticky", 32'(overrun_o), 32'd1);
    clr_overrun_i = 1'b1;
    tick();
    clr_overrun_i = 1'b0;
    check("ovr_clr", 32'(overrun_o), 32'd0);

    // Back-to-back tiles
    set_acc(1, 2, 3, 4);
    push(1, 0, 0); push(2, 1, 0); push(3, 2, 0); push(4, 3, 0);
    pulse_done();
    n = 0;
    while (out_idx_o != 2'd3 && n < 20) begin
      tick();
      n++;
    end
    check("b2b_reach_last", 32'(n < 20), 32'd1);
    set_acc(5, 6, 7, 8);
    push(5, 0, 0); push(6, 1, 0); push(7, 2, 0); push(8, 3, 0);
    pulse_done();
    check("b2b_valid",   32'(out_valid_o), 32'd1);
    check("b2b_idx",     32'(out_idx_o),   32'd0);
    check("b2b_overrun", 32'(overrun_o),   32'd0);
    wait_idle("b2b", n);
    check("b2b_cycles",  32'(n),           32'd4);
    check("b2b_ovr_end", 32'(overrun_o),   32'd0);

    // Reset mid-drain
    set_acc(1, 2, 3, 4);
    push(1, 0, 0); push(2, 1, 0); push(3, 2, 0); push(4, 3, 0);
    pulse_done();
    tick();
    tick();
    check("mid_idx_before", 32'(out_idx_o), 32'd2);
    rstn = 1'b0;
    sb_q.delete();
    #1;
    check("mid_rst_valid", 32'(out_valid_o), 32'd0);
    check("mid_rst_busy",  32'(busy_o),      32'd0);
    check("mid_rst_idx",   32'(out_idx_o),   32'd0);
    tick();
    rstn = 1'b1;
    tick();
    set_acc(21, -22, 23, 24);
    push(21, 0, 0); push(-22, 1, 0); push(23, 2, 0); push(24, 3, 0);
    pulse_done();
    check("post_rst_idx", 32'(out_idx_o), 32'd0);
    wait_idle("post_rst", n);

    tick();
    check("final_queue", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
